mux_rr_arbiter: RTL and testbench



---
 rtl/mux_rr_arbiter.sv | 126 ++++++++++++
 tb/tb_mux_rr_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// Four-way round-robin arbiter steering one WIDTH-bit valid/ready output channel through a 4:1 data mux.
// Latency: a request seen in IDLE is granted at the next edge; out_valid follows one cycle after the request.
// Backpressure: the grant is held while out_ready is low, and in_ready is only ever raised toward the grant holder.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   in_valid[3:0]     per-requester valid; d0..d3 are the matching data words
//   in_ready[3:0]     per-requester ready, one-hot toward the grant holder or zero
//   out_valid/out_data/out_ready   shared downstream channel
//   sel[1:0]          registered index of the current or last grant
// Optional macro MUX_RR_ARBITER_LAST_LOCK_EN adds in_last[3:0] and out_last. With it, the
// grant is held across multi-beat packets and released only on the beat marked last.
module mux_rr_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       in_valid,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
`ifdef MUX_RR_ARBITER_LAST_LOCK_EN
  input  logic [3:0]       in_last,
  output logic             out_last,
`endif
  output logic [3:0]       in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       sel
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_sel;
  logic [1:0] w_sel_nxt;
  logic [1:0] r_ptr;
  logic [1:0] w_ptr_nxt;
  logic       w_active;
  logic       w_xfer;
  logic       w_end;
  logic       w_found;
  logic [1:0] w_pick;

  // Round-robin search starting at r_ptr. The loop runs from the farthest offset down,
  // so the nearest requester at or after r_ptr is written last and wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      if (in_valid[r_ptr + 2'(k)]) begin
        w_found = 1'b1;
        w_pick  = r_ptr + 2'(k);
      end
    end
  end

  // Outputs are forced quiet while rst is high, so nothing moves in a reset cycle.
  assign w_active = (r_state == ST_GRANT) && !rst;
  assign w_xfer   = w_active && in_valid[r_sel] && out_ready;

`ifdef MUX_RR_ARBITER_LAST_LOCK_EN
  assign w_end    = w_xfer && in_last[r_sel];
  assign out_last = w_active && in_last[r_sel];
`else
  assign w_end    = w_xfer;
`endif

  always_comb begin
    out_data = d0;
    case (r_sel)
      2'd0:    out_data = d0;
      2'd1:    out_data = d1;
      2'd2:    out_data = d2;
      default: out_data = d3;
    endcase
  end

  assign out_valid = w_active && in_valid[r_sel];
  assign in_ready  = (w_active && out_ready) ? (4'b0001 << r_sel) : 4'b0000;
  assign sel       = r_sel;

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_sel_nxt   = w_pick;
          w_state_nxt = ST_GRANT;
        end
      end
      default: begin
        if (w_end) begin
          // Priority moves past the requester that was just served.
          w_ptr_nxt   = r_sel + 2'd1;
          w_state_nxt = ST_IDLE;
        end else if (!in_valid[r_sel]) begin
          // The grant holder withdrew its request without a transfer: release the
          // grant and keep priority where it was.
          w_state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_sel   <= 2'd0;
      r_ptr   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;

  typedef struct {
    int         id;
    logic       vld;
    logic [3:0] rdy;
    logic [3:0] dat;
    logic [1:0] sel;
    logic [3:0] lastv;
    logic       chk_last;
    logic       last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] in_valid = 4'b0000;
  logic [3:0] d0 = 4'h0;
  logic [3:0] d1 = 4'h0;
  logic [3:0] d2 = 4'h0;
  logic [3:0] d3 = 4'h0;
  logic [3:0] in_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_ready = 1'b0;
  logic [1:0] sel;
`ifdef MUX_RR_ARBITER_LAST_LOCK_EN
  logic [3:0] in_last = 4'hF;
  logic       out_last;
`endif

  // Data words staged here are applied together with the next step's inputs.
  logic [3:0] pend_d [4];
  exp_t       exp_q  [$];
  int         checks = 0;
  int         errors = 0;
  int         step_id = 0;

  mux_rr_arbiter #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
`ifdef MUX_RR_ARBITER_LAST_LOCK_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .sel       (sel)
  );

  always #5 clk = ~clk;

  task automatic set_d(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] e);
    pend_d[0] = a;
    pend_d[1] = b;
    pend_d[2] = c;
    pend_d[3] = e;
  endtask

  // One cycle of stimulus plus the hand-computed outputs expected during that cycle.
  task automatic step(input logic r, input logic [3:0] iv, input logic ordy,
                      input logic ev, input logic [3:0] er, input logic [3:0] ed,
                      input logic [1:0] es, input logic [3:0] il = 4'hF,
                      input logic cl = 1'b0, input logic el = 1'b0);
    exp_t e;
    @(posedge clk);
    #1;
    rst       = r;
    in_valid  = iv;
    out_ready = ordy;
    d0 = pend_d[0];
    d1 = pend_d[1];
    d2 = pend_d[2];
    d3 = pend_d[3];
`ifdef MUX_RR_ARBITER_LAST_LOCK_EN
    in_last = il;
`endif
    step_id++;
    e.id = step_id; e.vld = ev; e.rdy = er; e.dat = ed; e.sel = es;
    e.lastv = il; e.chk_last = cl; e.last = el;
    exp_q.push_back(e);
  endtask

  // Monitor: samples mid-cycle and compares against the oldest pending expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (out_valid !== e.vld) begin
        errors++;
        $display("FAIL step %0d out_valid: got %b expected %b", e.id, out_valid, e.vld);
      end
      checks++;
      if (in_ready !== e.rdy) begin
        errors++;
        $display("FAIL step %0d in_ready: got %b expected %b", e.id, in_ready, e.rdy);
      end
      checks++;
      if (out_data !== e.dat) begin
        errors++;
        $display("FAIL step %0d out_data: got %h expected %h", e.id, out_data, e.dat);
      end
      checks++;
      if (sel !== e.sel) begin
        errors++;
        $display("FAIL step %0d sel: got %0d expected %0d", e.id, sel, e.sel);
      end
`ifdef MUX_RR_ARBITER_LAST_LOCK_EN
      if (e.chk_last) begin
        checks++;
        if (out_last !== e.last) begin
          errors++;
          $display("FAIL step %0d out_last: got %b expected %b", e.id, out_last, e.last);
        end
      end
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset and idle
    set_d(4'h7, 4'h0, 4'h0, 4'h0);
    step(1, 4'b0000, 0, 0, 4'b0000, 4'h7, 2'd0);
    step(1, 4'b0000, 0, 0, 4'b0000, 4'h7, 2'd0);
    for (int i = 0; i < 5; i++) step(0, 4'b0000, 0, 0, 4'b0000, 4'h7, 2'd0);

    // Single requester 2, twice, with the mandatory bubble between
    set_d(4'h7, 4'h0, 4'hA, 4'h0);
    step(0, 4'b0100, 1, 0, 4'b0000, 4'h7, 2'd0);
    step(0, 4'b0100, 1, 1, 4'b0100, 4'hA, 2'd2);
    step(0, 4'b0100, 1, 0, 4'b0000, 4'hA, 2'd2);
    step(0, 4'b0100, 1, 1, 4'b0100, 4'hA, 2'd2);
    step(0, 4'b0000, 1, 0, 4'b0000, 4'hA, 2'd2);

    // Round robin from a fresh reset: 1,2,3,4,1 on alternate cycles
    set_d(4'h1, 4'h2, 4'h3, 4'h4);
    step(1, 4'b1111, 1, 0, 4'b0000, 4'h3, 2'd2);
    step(0, 4'b1111, 1, 0, 4'b0000, 4'h1, 2'd0);
    step(0, 4'b1111, 1, 1, 4'b0001, 4'h1, 2'd0);
    step(0, 4'b1111, 1, 0, 4'b0000, 4'h1, 2'd0);
    step(0, 4'b1111, 1, 1, 4'b0010, 4'h2, 2'd1);
    step(0, 4'b1111, 1, 0, 4'b0000, 4'h2, 2'd1);
    step(0, 4'b1111, 1, 1, 4'b0100, 4'h3, 2'd2);
    step(0, 4'b1111, 1, 0, 4'b0000, 4'h3, 2'd2);
    step(0, 4'b1111, 1, 1, 4'b1000, 4'h4, 2'd3);
    step(0, 4'b1111, 1, 0, 4'b0000, 4'h4, 2'd3);
    step(0, 4'b1111, 1, 1, 4'b0001, 4'h1, 2'd0);
    step(0, 4'b0000, 1, 0, 4'b0000, 4'h1, 2'd0);

    // Backpressure on requester 1, then the next grant goes to 2
    set_d(4'h1, 4'h5, 4'h3, 4'h4);
    step(0, 4'b0010, 0, 0, 4'b0000, 4'h1, 2'd0);
    for (int i = 0; i < 4; i++) step(0, 4'b0010, 0, 1, 4'b0000, 4'h5, 2'd1);
    step(0, 4'b0010, 1, 1, 4'b0010, 4'h5, 2'd1);
    step(0, 4'b1111, 1, 0, 4'b0000, 4'h5, 2'd1);
    step(0, 4'b1111, 1, 1, 4'b0100, 4'h3, 2'd2);

    // Wrap: after serving 3, requesters 0 and 3 both ask and 0 wins
    step(0, 4'b1000, 1, 0, 4'b0000, 4'h3, 2'd2);
    step(0, 4'b1000, 1, 1, 4'b1000, 4'h4, 2'd3);
    step(0, 4'b1001, 1, 0, 4'b0000, 4'h4, 2'd3);
    step(0, 4'b1001, 1, 1, 4'b0001, 4'h1, 2'd0);

    // Reset mid-grant: no ready pulse, priority returns to 0
    step(0, 4'b1001, 1, 0, 4'b0000, 4'h1, 2'd0);
    step(1, 4'b1001, 1, 0, 4'b0000, 4'h4, 2'd3);
    step(0, 4'b1001, 1, 0, 4'b0000, 4'h1, 2'd0);
    step(0, 4'b1001, 1, 1, 4'b0001, 4'h1, 2'd0);

    // Grant holder drops valid: grant released, priority unchanged
    step(0, 4'b0010, 0, 0, 4'b0000, 4'h1, 2'd0);
    step(0, 4'b0000, 0, 0, 4'b0000, 4'h5, 2'd1);
    step(0, 4'b0110, 1, 0, 4'b0000, 4'h5, 2'd1);
    step(0, 4'b0110, 1, 1, 4'b0010, 4'h5, 2'd1);
    step(0, 4'b0000, 1, 0, 4'b0000, 4'h5, 2'd1);

`ifdef MUX_RR_ARBITER_LAST_LOCK_EN
    // Three-beat packet from 0 held without bubbles, then 1 is granted
    step(1, 4'b0000, 1, 0, 4'b0000, 4'h5, 2'd1);
    step(0, 4'b0011, 1, 0, 4'b0000, 4'h1, 2'd0, 4'b0000, 1, 0);
    step(0, 4'b0011, 1, 1, 4'b0001, 4'h1, 2'd0, 4'b0000, 1, 0);
    step(0, 4'b0011, 1, 1, 4'b0001, 4'h1, 2'd0, 4'b0000, 1, 0);
    step(0, 4'b0011, 1, 1, 4'b0001, 4'h1, 2'd0, 4'b0001, 1, 1);
    step(0, 4'b0010, 1, 0, 4'b0000, 4'h1, 2'd0, 4'b0010, 1, 0);
    step(0, 4'b0010, 1, 1, 4'b0010, 4'h5, 2'd1, 4'b0010, 1, 1);
`endif

    // Let the monitor drain, bounded by a cycle budget.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
